// File: rtl/grf_sched_pkg.sv
// Shared types and helpers for the GRF writeback scheduler: slot layout,
// default latency depth and the issue-latency clamp.
package grf_sched_pkg;

   localparam int MAXLAT_DEF = 4;

   typedef struct packed {
      logic        valid;
      logic [4:0]  addr;
      logic [31:0] pc;
   } slot_t;

   // Latencies of 0 or above the slot depth fall back to the deepest slot.
   function automatic logic [3:0] clamp_lat(input logic [2:0] lat, input int maxlat);
      if (lat == 3'd0 || int'(lat) > maxlat)
         return 4'(maxlat);
      return {1'b0, lat};
   endfunction

endpackage

// File: rtl/grf_sched_cmp.sv
// Per-slot address comparators: RAW/WAW hit detection against the pending
// writes and the one-hot busy decode.
module grf_sched_cmp
   import grf_sched_pkg::*;
#(
   parameter int MAXLAT = MAXLAT_DEF
) (
   input  slot_t [MAXLAT-1:0] slots,
   input  logic  [4:0]        rs,
   input  logic  [4:0]        rt,
   input  logic               use_rs,
   input  logic               use_rt,
   input  logic               wr,
   input  logic  [4:0]        rd,
   output logic               raw,
   output logic               waw,
   output logic  [31:0]       busy
);

   logic [MAXLAT-1:0] hit_rs, hit_rt, hit_rd;

   for (genvar i = 0; i < MAXLAT; i++) begin : g_slot
      assign hit_rs[i] = slots[i].valid && (slots[i].addr == rs);
      assign hit_rt[i] = slots[i].valid && (slots[i].addr == rt);
      assign hit_rd[i] = slots[i].valid && (slots[i].addr == rd);
   end

   // $0 never creates a slot, but the nonzero guards keep it hazard-free regardless.
   assign raw = (use_rs && (rs != 5'd0) && (|hit_rs)) ||
                (use_rt && (rt != 5'd0) && (|hit_rt));
   assign waw = wr && (rd != 5'd0) && (|hit_rd);

   always_comb begin
      busy = '0;
      for (int i = 0; i < MAXLAT; i++)
         if (slots[i].valid)
            busy[slots[i].addr] = 1'b1;
      busy[0] = 1'b0;
   end

endmodule

// File: rtl/grf_wb_sched.sv
// GRF writeback scheduler: a shift register of result slots that delivers each
// accepted write to the register file exactly L cycles after issue, stalling on hazards.
module grf_wb_sched
   import grf_sched_pkg::*;
#(
   parameter int MAXLAT = MAXLAT_DEF
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        iss_valid,
   input  logic [4:0]  iss_rs,
   input  logic [4:0]  iss_rt,
   input  logic        iss_use_rs,
   input  logic        iss_use_rt,
   input  logic        iss_wr,
   input  logic [4:0]  iss_rd,
   input  logic [2:0]  iss_lat,
   input  logic [31:0] iss_pc,
   output logic        iss_stall,
   output logic        grf_we,
   output logic [4:0]  grf_waddr,
   output logic [31:0] grf_pc,
   output logic [31:0] busy,
   output logic [31:0] stall_cnt
);

   slot_t [MAXLAT-1:0] slots, slots_nxt;
   logic [3:0]         lat;
   logic               wr_req, raw, waw, struct_hz, accept;

   assign lat    = clamp_lat(iss_lat, MAXLAT);
   assign wr_req = iss_wr && (iss_rd != 5'd0);

   grf_sched_cmp #(.MAXLAT(MAXLAT)) u_cmp (
      .slots  (slots),
      .rs     (iss_rs),
      .rt     (iss_rt),
      .use_rs (iss_use_rs),
      .use_rt (iss_use_rt),
      .wr     (iss_wr),
      .rd     (iss_rd),
      .raw    (raw),
      .waw    (waw),
      .busy   (busy)
   );

   // Pre-shift slot[L] becomes post-shift slot[L-1]; L==MAXLAT lands in the refilled slot.
   always_comb begin
      struct_hz = 1'b0;
      for (int i = 0; i < MAXLAT; i++)
         if (wr_req && (4'(i) == lat))
            struct_hz = slots[i].valid;
   end

   assign iss_stall = !reset && iss_valid && (raw || waw || struct_hz);
   assign accept    = iss_valid && !iss_stall;

   always_comb begin
      for (int i = 0; i < MAXLAT - 1; i++)
         slots_nxt[i] = slots[i+1];
      slots_nxt[MAXLAT-1] = '0;
      for (int i = 0; i < MAXLAT; i++)
         if (accept && wr_req && (4'(i + 1) == lat))
            slots_nxt[i] = '{valid: 1'b1, addr: iss_rd, pc: iss_pc};
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         slots <= '0;
      else
         slots <= slots_nxt;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         stall_cnt <= '0;
      else if (iss_stall && (stall_cnt != 32'hFFFF_FFFF))
         stall_cnt <= stall_cnt + 32'd1;
   end

   assign grf_we    = slots[0].valid;
   assign grf_waddr = slots[0].valid ? slots[0].addr : 5'd0;
   assign grf_pc    = slots[0].valid ? slots[0].pc   : 32'd0;

endmodule

// File: tb/tb_grf_wb_sched.sv
// Directed bench for grf_wb_sched: expected GRF writes are queued at issue
// time and matched cycle-by-cycle against the write port.
module tb_grf_wb_sched;

   logic        clk = 1'b0;
   logic        reset;
   logic        iss_valid, iss_use_rs, iss_use_rt, iss_wr;
   logic [4:0]  iss_rs, iss_rt, iss_rd;
   logic [2:0]  iss_lat;
   logic [31:0] iss_pc;
   logic        iss_stall, grf_we;
   logic [4:0]  grf_waddr;
   logic [31:0] grf_pc, busy, stall_cnt;

   grf_wb_sched #(.MAXLAT(4)) dut (
      .clk        (clk),
      .reset      (reset),
      .iss_valid  (iss_valid),
      .iss_rs     (iss_rs),
      .iss_rt     (iss_rt),
      .iss_use_rs (iss_use_rs),
      .iss_use_rt (iss_use_rt),
      .iss_wr     (iss_wr),
      .iss_rd     (iss_rd),
      .iss_lat    (iss_lat),
      .iss_pc     (iss_pc),
      .iss_stall  (iss_stall),
      .grf_we     (grf_we),
      .grf_waddr  (grf_waddr),
      .grf_pc     (grf_pc),
      .busy       (busy),
      .stall_cnt  (stall_cnt)
   );

   always #5 clk = ~clk;

   typedef struct {
      int          cyc;
      logic [4:0]  addr;
      logic [31:0] pc;
   } exp_t;

   exp_t q[$];
   int   checks = 0;
   int   errors = 0;
   int   cyc    = 0;
   int   exp_sc = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   // Advance one cycle and compare the write port against the scoreboard.
   task automatic tick();
      exp_t e;
      @(posedge clk);
      #1;
      cyc++;
      if (q.size() > 0 && q[0].cyc == cyc) begin
         e = q.pop_front();
         chk("grf_we", 64'(grf_we), 64'd1);
         chk("grf_waddr", 64'(grf_waddr), 64'(e.addr));
         chk("grf_pc", 64'(grf_pc), 64'(e.pc));
      end else begin
         chk("grf_we_idle", 64'(grf_we), 64'd0);
      end
   endtask

   task automatic idle(input int n);
      iss_valid = 1'b0;
      for (int i = 0; i < n; i++) tick();
   endtask

   // Present one instruction, expect exactly exp_stall stall cycles, then acceptance.
   task automatic issue(input logic wr, input logic [4:0] rd, input logic [4:0] rs,
                        input logic urs, input logic [4:0] rt, input logic urt,
                        input logic [2:0] lat, input logic [31:0] pc, input int exp_stall);
      exp_t e;
      int   lc;
      lc = (lat == 3'd0 || lat > 3'd4) ? 4 : int'(lat);
      iss_valid = 1'b1; iss_wr = wr; iss_rd = rd; iss_rs = rs; iss_use_rs = urs;
      iss_rt = rt; iss_use_rt = urt; iss_lat = lat; iss_pc = pc;
      for (int i = 0; i < exp_stall; i++) begin
         #1;
         chk("iss_stall_hi", 64'(iss_stall), 64'd1);
         exp_sc++;
         tick();
      end
      #1;
      chk("iss_stall_lo", 64'(iss_stall), 64'd0);
      if (wr && rd != 5'd0) begin
         e.cyc = cyc + lc; e.addr = rd; e.pc = pc;
         q.push_back(e);
      end
      tick();
      iss_valid = 1'b0;
   endtask

   initial begin
      reset = 1'b1;
      iss_valid = 0; iss_wr = 0; iss_rd = 0; iss_rs = 0; iss_rt = 0;
      iss_use_rs = 0; iss_use_rt = 0; iss_lat = 3'd1; iss_pc = 0;
      repeat (2) @(posedge clk);
      #1;
      iss_valid = 1'b1; iss_rs = 5'd3; iss_use_rs = 1'b1;
      #1;
      chk("rst_grf_we", 64'(grf_we), 64'd0);
      chk("rst_waddr", 64'(grf_waddr), 64'd0);
      chk("rst_pc", 64'(grf_pc), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_stall", 64'(iss_stall), 64'd0);
      chk("rst_stall_cnt", 64'(stall_cnt), 64'd0);
      iss_valid = 1'b0; iss_use_rs = 1'b0;
      @(negedge clk);
      reset = 1'b0;
      tick();

      // Single write, L=3: write lands 3 cycles later, busy[5] during cycles 1..3.
      issue(1, 5'd5, 0, 0, 0, 0, 3'd3, 32'h3000, 0);
      for (int k = 1; k <= 4; k++) begin
         chk("busy_single", 64'(busy), (k <= 3) ? 64'h20 : 64'h0);
         idle(1);
      end
      idle(2);

      // RAW on rs with no bypass.
      issue(1, 5'd8, 0, 0, 0, 0, 3'd2, 32'h4000, 0);
      issue(0, 5'd0, 5'd8, 1, 0, 0, 3'd1, 32'h4004, 2);
      chk("stall_cnt_raw", 64'(stall_cnt), 64'(exp_sc));
      idle(5);

      // Unused source ignored; RAW on rt against slot[0].
      issue(1, 5'd20, 0, 0, 0, 0, 3'd2, 32'h4100, 0);
      issue(0, 5'd0, 5'd20, 0, 0, 0, 3'd1, 32'h4104, 0);
      issue(0, 5'd0, 0, 0, 5'd20, 1, 3'd1, 32'h4108, 1);
      idle(5);

      // Structural: two writes would share a slot.
      issue(1, 5'd4, 0, 0, 0, 0, 3'd3, 32'h5000, 0);
      issue(1, 5'd6, 0, 0, 0, 0, 3'd2, 32'h5004, 1);
      idle(5);

      // $0 and non-writing instructions create nothing.
      issue(1, 5'd0, 0, 0, 0, 0, 3'd2, 32'h6000, 0);
      chk("busy_r0", 64'(busy), 64'd0);
      issue(0, 5'd0, 5'd0, 1, 0, 0, 3'd1, 32'h6004, 0);
      chk("busy_r0b", 64'(busy), 64'd0);
      issue(0, 5'd7, 0, 0, 0, 0, 3'd1, 32'h6008, 0);
      chk("busy_nowr", 64'(busy), 64'd0);
      idle(5);

      // WAW: younger short-latency write waits for the older one.
      issue(1, 5'd9, 0, 0, 0, 0, 3'd4, 32'h7000, 0);
      issue(1, 5'd9, 0, 0, 0, 0, 3'd1, 32'h7004, 4);
      idle(5);

      // Latency clamp: 7 and 0 behave as MAXLAT.
      issue(1, 5'd3, 0, 0, 0, 0, 3'd7, 32'h8000, 0);
      issue(1, 5'd2, 0, 0, 0, 0, 3'd0, 32'h8004, 0);
      chk("busy_clamp", 64'(busy), 64'h0C);
      idle(6);
      chk("stall_cnt_mid", 64'(stall_cnt), 64'(exp_sc));

      // Mid-operation asynchronous reset drops all pending writes.
      issue(1, 5'd10, 0, 0, 0, 0, 3'd4, 32'h9000, 0);
      issue(1, 5'd11, 0, 0, 0, 0, 3'd4, 32'h9004, 0);
      issue(1, 5'd12, 0, 0, 0, 0, 3'd4, 32'h9008, 0);
      idle(1);
      chk("busy_pre_rst", 64'(busy), 64'h1C00);
      #2;
      reset = 1'b1;
      #1;
      chk("arst_grf_we", 64'(grf_we), 64'd0);
      chk("arst_waddr", 64'(grf_waddr), 64'd0);
      chk("arst_pc", 64'(grf_pc), 64'd0);
      chk("arst_busy", 64'(busy), 64'd0);
      chk("arst_stall_cnt", 64'(stall_cnt), 64'd0);
      q.delete();
      exp_sc = 0;
      @(negedge clk);
      reset = 1'b0;
      for (int k = 0; k < 6; k++) begin
         tick();
         chk("busy_post_rst", 64'(busy), 64'd0);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #50000;
      errors++;
      $display("FAIL timeout reached: checks=%0d", checks);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $fatal(1, "timeout");
   end

endmodule
